stream_register_file: RTL and testbench

STREAM_REGISTER_FILE -- requirements
Module: stream_register_file

---
 rtl/stream_register_file.sv | 97 +++++++++
 tb/tb_stream_register_file.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_register_file.sv
// stream_register_file: tiled vector register file, two 1-cycle read ports, clear sweep; `define SRF_BYPASS_EN for write-to-read forwarding
module stream_register_file #(
  parameter int NUM_TILES = 20,
  parameter int LANE_WIDTH = 16,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W = $clog2(NUM_REGS),
  localparam int DW = NUM_TILES * LANE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [NUM_TILES-1:0] wr_tile_mask,
  input  logic [DW-1:0]        wr_data,
  input  logic [1:0]           rd_en,
  input  logic [ADDR_W-1:0]    rd_addr0,
  input  logic [ADDR_W-1:0]    rd_addr1,
  output logic [DW-1:0]        rd_data0,
  output logic [DW-1:0]        rd_data1,
  output logic [1:0]           rd_valid,
  output logic [1:0]           rd_err,
  input  logic                 clr_req,
  output logic                 busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [DW-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0] written;
  logic [DW-1:0] merged;
  logic wr_fire;
  logic [1:0] hit;
  assign busy = state == CLEAR;
  assign wr_ready = state == IDLE && !clr_req;
  assign wr_fire = wr_valid && wr_ready;
`ifdef SRF_BYPASS_EN
  assign hit = {2{wr_fire}} & {rd_addr1 == wr_addr, rd_addr0 == wr_addr};
`else
  assign hit = 2'b00;
`endif
  // state and sweep index register; reset starts a fresh sweep
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  // sweep advances one register per cycle and stops at the last index
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (state == IDLE) begin
      state_n = clr_req ? CLEAR : IDLE;
      idx_n = '0;
    end else begin
      state_n = idx == LAST ? IDLE : CLEAR;
      idx_n = idx == LAST ? '0 : idx + 1'b1;
    end
  end
  // new register contents: masked tiles from wr_data, the rest kept
  always_comb begin
    merged = mem[wr_addr];
    for (int t = 0; t < NUM_TILES; t++)
      if (wr_tile_mask[t]) merged[t*LANE_WIDTH +: LANE_WIDTH] = wr_data[t*LANE_WIDTH +: LANE_WIDTH];
  end
  // storage: sweep zeroes one register, otherwise accepted writes land
  always_ff @(posedge clk)
    if (state == CLEAR) begin
      mem[idx] <= '0;
      written[idx] <= 1'b0;
    end else if (wr_fire) begin
      mem[wr_addr] <= merged;
      written[wr_addr] <= 1'b1;
    end
  // registered read ports; data and error hold when no read is served
  always_ff @(posedge clk)
    if (rst) begin
      rd_valid <= 2'b00;
      rd_err <= 2'b00;
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      rd_valid <= state == IDLE ? rd_en : 2'b00;
      if (state == IDLE && rd_en[0]) begin
        rd_data0 <= hit[0] ? merged : mem[rd_addr0];
        rd_err[0] <= !hit[0] && !written[rd_addr0];
      end
      if (state == IDLE && rd_en[1]) begin
        rd_data1 <= hit[1] ? merged : mem[rd_addr1];
        rd_err[1] <= !hit[1] && !written[rd_addr1];
      end
    end
endmodule

// File: tb/tb_stream_register_file.sv
// tb_stream_register_file: random and directed checks of stream_register_file against an array-level model
module tb_stream_register_file;
  localparam int NT = 20;
  localparam int LW = 16;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = NT * LW;
`ifdef SRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [NT-1:0] wr_tile_mask = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0] rd_en = 2'b00;
  logic [AW-1:0] rd_addr0 = '0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [DW-1:0] rd_data0, rd_data1;
  logic [1:0] rd_valid, rd_err;
  logic clr_req = 1'b0;
  logic busy;
  stream_register_file dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_tile_mask(wr_tile_mask), .wr_data(wr_data), .rd_en(rd_en), .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_valid(rd_valid),
    .rd_err(rd_err), .clr_req(clr_req), .busy(busy)
  );
  always #5 clk = ~clk;
  int total = 0;
  int passed = 0;
  bit chk_on = 1'b0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  // reference model: whole-register arrays, a clearing flag and sweep position
  logic [DW-1:0] m_mem [NR];
  bit m_wr [NR];
  bit m_clr = 1'b0;
  int m_pos = 0;
  logic [1:0] m_rv = 2'b00;
  logic [1:0] m_re = 2'b00;
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] mg;
  logic [AW-1:0] a;
  bit fire;
  always @(posedge clk) begin
    if (rst) begin
      m_clr = 1'b1;
      m_pos = 0;
      m_rv = 2'b00;
      m_re = 2'b00;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else begin
      fire = !m_clr && !clr_req && wr_valid;
      mg = m_mem[wr_addr];
      for (int t = 0; t < NT; t++)
        if (wr_tile_mask[t]) mg[t*LW +: LW] = wr_data[t*LW +: LW];
      for (int p = 0; p < 2; p++) begin
        a = p == 1 ? rd_addr1 : rd_addr0;
        m_rv[p] = !m_clr && rd_en[p];
        if (m_rv[p]) begin
          if (BYP && fire && a == wr_addr) begin
            m_rd[p] = mg;
            m_re[p] = 1'b0;
          end else begin
            m_rd[p] = m_mem[a];
            m_re[p] = !m_wr[a];
          end
        end
      end
      if (m_clr) begin
        m_mem[m_pos] = '0;
        m_wr[m_pos] = 1'b0;
        m_clr = m_pos != NR - 1;
        m_pos++;
      end else if (clr_req) begin
        m_clr = 1'b1;
        m_pos = 0;
      end
      if (fire) begin
        m_mem[wr_addr] = mg;
        m_wr[wr_addr] = 1'b1;
      end
    end
  end
  // compare every DUT output against the model each cycle
  always @(negedge clk)
    if (chk_on) begin
      chk("busy", busy, m_clr);
      chk("wr_ready", wr_ready, !m_clr && !clr_req);
      chk("rd_valid", rd_valid, m_rv);
      chk("rd_err", rd_err, m_re);
      chk("rd_data0", rd_data0, m_rd[0]);
      chk("rd_data1", rd_data1, m_rd[1]);
    end
  task automatic nxt;
    @(negedge clk);
    #1;
  endtask
  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction
  int n;
  logic [DW-1:0] d1;
  initial begin
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    #1;
    chk("reset_sweep_len", n, 32);
    chk("ready_after_reset", wr_ready, 1);
    wr_valid = 1'b1; wr_addr = 5; wr_tile_mask = '1; wr_data = {NT{16'hA5A5}};
    nxt;
    wr_valid = 1'b0; rd_en = 2'b11; rd_addr0 = 5; rd_addr1 = 5;
    nxt;
    rd_en = 2'b00;
    chk("r5_port0", rd_data0, {NT{16'hA5A5}});
    chk("r5_port1", rd_data1, {NT{16'hA5A5}});
    chk("r5_valid", rd_valid, 2'b11);
    chk("r5_err", rd_err, 2'b00);
    clr_req = 1'b1;
    nxt;
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; nxt; end
    chk("clear_len", n, 32);
    wr_valid = 1'b1; wr_addr = 3; wr_tile_mask = 20'h00001; wr_data = rnd_vec();
    wr_data[15:0] = 16'h1234;
    nxt;
    wr_valid = 1'b0; rd_en = 2'b11; rd_addr0 = 3; rd_addr1 = 4;
    nxt;
    rd_en = 2'b00;
    chk("r3_masked", rd_data0, 320'h1234);
    chk("r4_zero", rd_data1, 0);
    chk("r3r4_err", rd_err, 2'b10);
    wr_valid = 1'b1; wr_addr = 7; wr_tile_mask = '1; wr_data = {NT{16'h1111}};
    nxt;
    wr_data = {NT{16'h2222}}; rd_en = 2'b11; rd_addr0 = 7; rd_addr1 = 7;
    nxt;
    wr_valid = 1'b0; rd_en = 2'b00;
    chk("r7_same_cycle", rd_data0, BYP ? {NT{16'h2222}} : {NT{16'h1111}});
    chk("r7_ports_equal", rd_data1, BYP ? {NT{16'h2222}} : {NT{16'h1111}});
    rd_en = 2'b01;
    nxt;
    rd_en = 2'b00;
    chk("r7_after", rd_data0, {NT{16'h2222}});
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 9; wr_tile_mask = '1; wr_data = rnd_vec();
    #1;
    chk("clr_blocks_write", wr_ready, 0);
    nxt;
    clr_req = 1'b0; wr_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      rd_en = n == 10 ? 2'b11 : 2'b00;
      clr_req = n == 20;
      if (n == 11) chk("rd_dropped", rd_valid, 2'b00);
      n++;
      nxt;
    end
    rd_en = 2'b00; clr_req = 1'b0;
    chk("sweep_not_restarted", n, 32);
    rd_en = 2'b01; rd_addr0 = 9;
    nxt;
    rd_en = 2'b00;
    chk("r9_not_written", rd_err[0], 1);
    d1 = rnd_vec();
    wr_valid = 1'b1; wr_addr = 1; wr_tile_mask = '1; wr_data = d1;
    nxt;
    wr_valid = 1'b0; rd_en = 2'b11; rd_addr0 = 1; rd_addr1 = 1;
    nxt;
    rd_en = 2'b00;
    chk("r1_data", rd_data0, d1);
    clr_req = 1'b1;
    nxt;
    clr_req = 1'b0;
    repeat (15) nxt;
    rst = 1'b1; rd_en = 2'b11;
    nxt;
    rst = 1'b0; rd_en = 2'b00;
    chk("rst_valid", rd_valid, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_data0", rd_data0, 0);
    chk("rst_data1", rd_data1, 0);
    n = 0;
    while (busy && n < 100) begin n++; nxt; end
    chk("rst_mid_sweep_len", n, 32);
    for (int i = 0; i < 800; i++) begin
      rst = $urandom_range(0, 299) == 0;
      clr_req = $urandom_range(0, 39) == 0;
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr = $urandom_range(0, 3) == 0 ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 7));
      wr_tile_mask = NT'($urandom);
      wr_data = rnd_vec();
      rd_en = 2'($urandom);
      rd_addr0 = AW'($urandom_range(0, 7));
      rd_addr1 = $urandom_range(0, 3) == 0 ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 7));
      nxt;
    end
    rst = 1'b0; clr_req = 1'b0; wr_valid = 1'b0; rd_en = 2'b00;
    nxt;
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
